// File: rtl/div_iter.sv
// div_iter: iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU).
// One restoring-division step per cycle using a 33-bit compare-subtract.
// Operation flow: IDLE -> PREP -> ITER (32 steps) -> FIN (done pulse) -> IDLE.
// Divide-by-zero and signed overflow bypass ITER and finish from PREP.
// Optional feature macro: DIV_SIGNED_EN. When it is defined, DIV/REM use signed
// operands, including magnitude conversion, sign fixup and the overflow case.
// When it is undefined, op[0] is ignored and every op is unsigned.
// All outputs are driven directly from flops.

module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Two's complement negation, shared by magnitude conversion and sign fixup.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = (~x) + 32'd1;
  endfunction

  // Magnitude of a value that is signed only when is_signed is set.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    if (is_signed && x[31]) begin
      mag32 = neg32(x);
    end else begin
      mag32 = x;
    end
  endfunction

  // Architectural state
  state_e      state_q,   state_d;
  logic        rem_sel_q, rem_sel_d;  // 1: return remainder, 0: quotient
  logic [31:0] a_q,       a_d;        // raw dividend captured at start
  logic [31:0] b_q,       b_d;        // raw divisor, then |divisor| during ITER
  logic [31:0] rem_q,     rem_d;      // partial remainder
  logic [31:0] quo_q,     quo_d;      // dividend bits shifting out, quotient bits shifting in
  logic [4:0]  cnt_q,     cnt_d;      // ITER step counter, 0..31
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic [31:0] result_q,  result_d;

`ifdef DIV_SIGNED_EN
  logic        sgn_op_q,  sgn_op_d;   // op is DIV or REM
  logic        qneg_q,    qneg_d;     // quotient must be negated at FIN
  logic        rneg_q,    rneg_d;     // remainder must be negated at FIN
`else
  logic        op_unused_s;           // op[0] selects signedness only
  assign op_unused_s = op[0];
`endif

  // Datapath helpers
  logic [32:0] t_s;          // {rem, next dividend bit}
  logic [32:0] diff_s;       // t - {0, |divisor|}
  logic [31:0] step_rem_s;   // remainder after this step
  logic [31:0] step_quo_s;   // quotient register after this step
  logic [31:0] fin_quo_s;    // final quotient with sign applied
  logic [31:0] fin_rem_s;    // final remainder with sign applied
  logic [31:0] mag_a_s;      // |dividend| for the iteration
  logic [31:0] mag_b_s;      // |divisor| for the iteration
  logic        ovf_s;        // signed 0x80000000 / -1

  // One restoring step and the final sign fixup for the step that ends ITER.
  always_comb begin
    t_s        = {rem_q, quo_q[31]};
    diff_s     = t_s - {1'b0, b_q};
    if (diff_s[32] == 1'b0) begin
      step_rem_s = diff_s[31:0];
    end else begin
      step_rem_s = t_s[31:0];
    end
    step_quo_s = {quo_q[30:0], ~diff_s[32]};
`ifdef DIV_SIGNED_EN
    fin_quo_s  = qneg_q ? neg32(step_quo_s) : step_quo_s;
    fin_rem_s  = rneg_q ? neg32(step_rem_s) : step_rem_s;
`else
    fin_quo_s  = step_quo_s;
    fin_rem_s  = step_rem_s;
`endif
  end

  // Operand magnitudes and overflow detection used while in PREP.
  always_comb begin
`ifdef DIV_SIGNED_EN
    mag_a_s = mag32(a_q, sgn_op_q);
    mag_b_s = mag32(b_q, sgn_op_q);
    ovf_s   = sgn_op_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
`else
    mag_a_s = mag32(a_q, 1'b0);
    mag_b_s = mag32(b_q, 1'b0);
    ovf_s   = 1'b0;
`endif
  end

  // Next-state and next-output computation for the whole operation.
  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
`ifdef DIV_SIGNED_EN
    sgn_op_d  = sgn_op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
`endif

    if (flush) begin
      // Abort: back to IDLE without done; the result register keeps its value.
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_PREP;
            busy_d    = 1'b1;
            rem_sel_d = op[1];
            a_d       = dividend;
            b_d       = divisor;
`ifdef DIV_SIGNED_EN
            sgn_op_d  = ~op[0];
`endif
          end else begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
          end
        end

        S_PREP: begin
`ifdef DIV_SIGNED_EN
          qneg_d = sgn_op_q & (a_q[31] ^ b_q[31]);
          rneg_d = sgn_op_q & a_q[31];
`endif
          if (b_q == 32'd0) begin
            // Divide by zero: all-ones quotient, raw dividend as remainder.
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = rem_sel_q ? a_q : 32'hFFFF_FFFF;
          end else if (ovf_s) begin
            // Signed overflow: quotient wraps to the dividend, remainder zero.
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = rem_sel_q ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d  = S_ITER;
            rem_d    = 32'd0;
            quo_d    = mag_a_s;
            b_d      = mag_b_s;
            cnt_d    = 5'd0;
          end
        end

        S_ITER: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // Last step: the finished, sign-corrected value lands with done.
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = rem_sel_q ? fin_rem_s : fin_quo_s;
          end else begin
            state_d  = S_ITER;
          end
        end

        S_FIN: begin
          // done was raised on entry; start is not sampled in this cycle.
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
`ifdef DIV_SIGNED_EN
      sgn_op_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
`ifdef DIV_SIGNED_EN
      sgn_op_q  <= sgn_op_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: the driver pushes the expected result and the
// expected done cycle offset when it issues a start, and a monitor pops and
// compares every time done is seen.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_SIGNED_EN
  localparam logic [31:0] E_DIV_M7_2   = 32'hFFFF_FFFD;
  localparam logic [31:0] E_REM_M7_2   = 32'hFFFF_FFFF;
  localparam logic [31:0] E_DIV_OVF    = 32'h8000_0000;
  localparam logic [31:0] E_REM_OVF    = 32'h0000_0000;
  localparam int          L_OVF        = 2;
  localparam logic [31:0] E_DIV_7_M2   = 32'hFFFF_FFFD;
  localparam logic [31:0] E_REM_7_M2   = 32'h0000_0001;
`else
  localparam logic [31:0] E_DIV_M7_2   = 32'h7FFF_FFFC;
  localparam logic [31:0] E_REM_M7_2   = 32'h0000_0001;
  localparam logic [31:0] E_DIV_OVF    = 32'h0000_0000;
  localparam logic [31:0] E_REM_OVF    = 32'h8000_0000;
  localparam int          L_OVF        = 34;
  localparam logic [31:0] E_DIV_7_M2   = 32'h0000_0000;
  localparam logic [31:0] E_REM_7_M2   = 32'h0000_0007;
`endif

  div_iter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge N, cyc == N; that interval is cycle N+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_res;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result %h, required no done", result);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (result !== e.res) begin
          n_fail++;
          $display("FAIL result: got %h, required %h (accepted at edge %0d)", result, e.res, e.acc);
        end
        n_cmp++;
        if ((cyc + 1 - e.acc) != e.lat) begin
          n_fail++;
          $display("FAIL latency: got done at T+%0d, required T+%0d", cyc + 1 - e.acc, e.lat);
        end
      end
    end
  end

  task automatic expect_op(input logic [31:0] r, input int lat);
    exp_t e;
    e.res = r;
    e.acc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_busy_released"}, 32'(busy), 32'd0);
  endtask

  // Issue one operation at the next negedge and wait for it to finish.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input int lat);
    @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    expect_op(r, lat);
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0BAD_F00D;
    wait_idle(nm);
    last_res = r;
  endtask

  initial begin
    int t0;
    int k;
    reset    = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'b00;
    dividend = 32'd0;
    divisor  = 32'd0;
    last_res = 32'd0;

    repeat (2) @(negedge clk);
    chk("reset_busy",   32'(busy), 32'd0);
    chk("reset_done",   32'(done), 32'd0);
    chk("reset_result", result,    32'd0);
    reset = 1'b0;

    // Main function, signed cases and boundary conditions
    run_op("divu_100_7",   OP_DIVU, 32'd100,         32'd7,           32'd14,          34);
    run_op("remu_100_7",   OP_REMU, 32'd100,         32'd7,           32'd2,           34);
    run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,   32'd2,           E_DIV_M7_2,      34);
    run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,   32'd2,           E_REM_M7_2,      34);
    run_op("div_7_m2",     OP_DIV,  32'd7,           32'hFFFF_FFFE,   E_DIV_7_M2,      34);
    run_op("rem_7_m2",     OP_REM,  32'd7,           32'hFFFF_FFFE,   E_REM_7_M2,      34);
    run_op("div_ovf",      OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   E_DIV_OVF,       L_OVF);
    run_op("rem_ovf",      OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   E_REM_OVF,       L_OVF);
    run_op("divu_by0",     OP_DIVU, 32'd1234,        32'd0,           32'hFFFF_FFFF,   2);
    run_op("remu_by0",     OP_REMU, 32'd1234,        32'd0,           32'd1234,        2);
    run_op("rem_m7_by0",   OP_REM,  32'hFFFF_FFF9,   32'd0,           32'hFFFF_FFF9,   2);
    run_op("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   34);
    run_op("remu_max_10",  OP_REMU, 32'hFFFF_FFFF,   32'd10,          32'd5,           34);
    run_op("divu_5_7",     OP_DIVU, 32'd5,           32'd7,           32'd0,           34);

    // Flush mid-operation: busy drops, no done, result unchanged
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy",   32'(busy), 32'd0);
    chk("flush_result", result,    last_res);
    run_op("after_flush", OP_DIVU, 32'd50, 32'd5, 32'd10, 34);

    // Flush together with start in IDLE drops the start
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);

    // Start while busy is ignored; start in the done cycle is not taken
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd100; divisor = 32'd10; start = 1'b1;
    expect_op(32'd10, 34);
    @(negedge clk);
    dividend = 32'd81; divisor = 32'd9;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("busy_start_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("start_in_done_cycle", 32'(busy), 32'd0);
    expect_op(32'd9, 34);
    @(negedge clk);
    start = 1'b0;
    wait_idle("start_after_done");
    last_res = 32'd9;

    // Asynchronous reset mid-operation
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 19) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy",   32'(busy), 32'd0);
    chk("async_reset_done",   32'(done), 32'd0);
    chk("async_reset_result", result,    32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = 32'd0;
    run_op("after_reset_div", OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);
    run_op("after_reset_rem", OP_REMU, 32'd1000, 32'd3, 32'd1,   34);

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_result_held", result, last_res);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
